// File: rtl/stream_ax_pkg.sv
// ============================================================================
// Module      : stream_ax_pkg
// Description : Shared packet-image definition for the AXI address-channel
//               stream link (serializer and deserializer ends).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package stream_ax_pkg;

  // Transaction type carried in image bit 0
  localparam logic TYPE_AR = 1'b0;
  localparam logic TYPE_AW = 1'b1;

  // Fixed-width fields of the image
  localparam int TYPE_W   = 1;
  localparam int SIZE_W   = 3;
  localparam int BURST_W  = 2;
  localparam int CACHE_W  = 4;
  localparam int PROT_W   = 3;
  localparam int REGION_W = 4;
  localparam int QOS_W    = 4;

  // Field order above the type bit, LSB first
  localparam int F_ID     = 0;
  localparam int F_ADDR   = 1;
  localparam int F_LEN    = 2;
  localparam int F_SIZE   = 3;
  localparam int F_BURST  = 4;
  localparam int F_LOCK   = 5;
  localparam int F_CACHE  = 6;
  localparam int F_PROT   = 7;
  localparam int F_REGION = 8;
  localparam int F_QOS    = 9;
  localparam int F_USER   = 10;
  localparam int F_END    = 11;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_DISCARD = 2'd2
  } state_e;

  function automatic int field_width(input int f, input int id_w, input int addr_w,
                                     input int len_w, input int lock_w, input int user_w);
    case (f)
      F_ID:     return id_w;
      F_ADDR:   return addr_w;
      F_LEN:    return len_w;
      F_SIZE:   return SIZE_W;
      F_BURST:  return BURST_W;
      F_LOCK:   return lock_w;
      F_CACHE:  return CACHE_W;
      F_PROT:   return PROT_W;
      F_REGION: return REGION_W;
      F_QOS:    return QOS_W;
      F_USER:   return user_w;
      default:  return 0;
    endcase
  endfunction

  // Bit offset of field f inside the image
  function automatic int field_offset(input int f, input int id_w, input int addr_w,
                                      input int len_w, input int lock_w, input int user_w);
    int off;
    off = TYPE_W;
    for (int i = 0; i < f; i++) off += field_width(i, id_w, addr_w, len_w, lock_w, user_w);
    return off;
  endfunction

  function automatic int pkt_bits(input int id_w, input int addr_w, input int len_w,
                                  input int lock_w, input int user_w);
    return field_offset(F_END, id_w, addr_w, len_w, lock_w, user_w);
  endfunction

  function automatic int beats(input int pkt, input int data_w);
    return (pkt + data_w - 1) / data_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stream_beat_assembler.sv
// ============================================================================
// Module      : stream_beat_assembler
// Description : Collects stream beats into the packet image register and
//               flags complete, short and long packets.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_beat_assembler #(
  parameter int DATA_WIDTH = 128,
  parameter int BEATS      = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_WIDTH-1:0]       beat_data,
  input  logic                        beat_accept,
  input  logic                        beat_last,
  input  logic                        clear,
  output logic                        done,
  output logic                        done_type,
  output logic                        short_det,
  output logic                        long_det,
  output logic                        err_short,
  output logic                        err_long,
  output logic [BEATS*DATA_WIDTH-1:0] image
);

  localparam int              CNT_W    = $clog2(BEATS + 1);
  localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(BEATS - 1);

  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [BEATS*DATA_WIDTH-1:0] image_q, image_d;
  logic                        err_short_q, err_short_d;
  logic                        err_long_q, err_long_d;
  logic                        at_last;

  // Packet-shape detection, beat storage and counter update
  always_comb begin
    at_last   = (cnt_q == LAST_POS);
    done      = beat_accept & beat_last & at_last;
    short_det = beat_accept & beat_last & ~at_last;
    long_det  = beat_accept & ~beat_last & at_last;
    // With a single-beat image the type bit arrives on the completing beat
    done_type = (cnt_q == '0) ? beat_data[0] : image_q[0];

    image_d = image_q;
    for (int k = 0; k < BEATS; k++) begin
      if (beat_accept && (cnt_q == CNT_W'(k))) image_d[k*DATA_WIDTH +: DATA_WIDTH] = beat_data;
    end

    cnt_d = cnt_q;
    if (beat_accept) begin
      if (short_det || long_det) cnt_d = '0;
      else                       cnt_d = cnt_q + CNT_W'(1);
    end else if (clear) begin
      cnt_d = '0;
    end

    err_short_d = short_det;
    err_long_d  = long_det;
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      image_q     <= '0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      image_q     <= image_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
    end
  end

  assign image     = image_q;
  assign err_short = err_short_q;
  assign err_long  = err_long_q;

endmodule

`default_nettype wire

// File: rtl/stream_to_axi_ax.sv
// ============================================================================
// Module      : stream_to_axi_ax
// Description : Rebuilds captured AR/AW transactions from stream packets and
//               replays them on an AXI4 master address channel.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_to_axi_ax
  import stream_ax_pkg::*;
#(
  parameter int DATA_WIDTH    = 128,
  parameter int ADDR_WIDTH    = 64,
  parameter int ID_WIDTH      = 32,
  parameter int BURST_LEN     = 8,
  parameter int LOCK_WIDTH    = 2,
  parameter int USER_WIDTH    = 64,
  parameter int DEST_WIDTH    = 32,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_WIDTH-1:0]    stream_tdata,
  input  logic                     stream_tvalid,
  input  logic                     stream_tlast,
  output logic                     stream_tready,
  input  logic [ID_WIDTH-1:0]      stream_tid,
  input  logic [DEST_WIDTH-1:0]    stream_tdest,
  input  logic [DATA_WIDTH/8-1:0]  stream_tstrb,
  input  logic [DATA_WIDTH/8-1:0]  stream_tkeep,
  input  logic [USER_WIDTH-1:0]    stream_tuser,
  output logic [ID_WIDTH-1:0]      AXIM_arid,
  output logic [ADDR_WIDTH-1:0]    AXIM_araddr,
  output logic [BURST_LEN-1:0]     AXIM_arlen,
  output logic [2:0]               AXIM_arsize,
  output logic [1:0]               AXIM_arburst,
  output logic [LOCK_WIDTH-1:0]    AXIM_arlock,
  output logic [3:0]               AXIM_arcache,
  output logic [2:0]               AXIM_arprot,
  output logic [3:0]               AXIM_arregion,
  output logic [3:0]               AXIM_arqos,
  output logic [USER_WIDTH-1:0]    AXIM_aruser,
  output logic                     AXIM_arvalid,
  input  logic                     AXIM_arready,
  output logic [ID_WIDTH-1:0]      AXIM_awid,
  output logic [ADDR_WIDTH-1:0]    AXIM_awaddr,
  output logic [BURST_LEN-1:0]     AXIM_awlen,
  output logic [2:0]               AXIM_awsize,
  output logic [1:0]               AXIM_awburst,
  output logic [LOCK_WIDTH-1:0]    AXIM_awlock,
  output logic [3:0]               AXIM_awcache,
  output logic [2:0]               AXIM_awprot,
  output logic [3:0]               AXIM_awregion,
  output logic [3:0]               AXIM_awqos,
  output logic [USER_WIDTH-1:0]    AXIM_awuser,
  output logic                     AXIM_awvalid,
  input  logic                     AXIM_awready,
  output logic                     err_short,
  output logic                     err_long,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  localparam int PKT_BITS = pkt_bits(ID_WIDTH, ADDR_WIDTH, BURST_LEN, LOCK_WIDTH, USER_WIDTH);
  localparam int BEATS    = beats(PKT_BITS, DATA_WIDTH);
  localparam int IMG_BITS = BEATS * DATA_WIDTH;

  localparam int O_ID     = field_offset(F_ID,     ID_WIDTH, ADDR_WIDTH, BURST_LEN, LOCK_WIDTH, USER_WIDTH);
  localparam int O_ADDR   = field_offset(F_ADDR,   ID_WIDTH, ADDR_WIDTH, BURST_LEN, LOCK_WIDTH, USER_WIDTH);
  localparam int O_LEN    = field_offset(F_LEN,    ID_WIDTH, ADDR_WIDTH, BURST_LEN, LOCK_WIDTH, USER_WIDTH);
  localparam int O_SIZE   = field_offset(F_SIZE,   ID_WIDTH, ADDR_WIDTH, BURST_LEN, LOCK_WIDTH, USER_WIDTH);
  localparam int O_BURST  = field_offset(F_BURST,  ID_WIDTH, ADDR_WIDTH, BURST_LEN, LOCK_WIDTH, USER_WIDTH);
  localparam int O_LOCK   = field_offset(F_LOCK,   ID_WIDTH, ADDR_WIDTH, BURST_LEN, LOCK_WIDTH, USER_WIDTH);
  localparam int O_CACHE  = field_offset(F_CACHE,  ID_WIDTH, ADDR_WIDTH, BURST_LEN, LOCK_WIDTH, USER_WIDTH);
  localparam int O_PROT   = field_offset(F_PROT,   ID_WIDTH, ADDR_WIDTH, BURST_LEN, LOCK_WIDTH, USER_WIDTH);
  localparam int O_REGION = field_offset(F_REGION, ID_WIDTH, ADDR_WIDTH, BURST_LEN, LOCK_WIDTH, USER_WIDTH);
  localparam int O_QOS    = field_offset(F_QOS,    ID_WIDTH, ADDR_WIDTH, BURST_LEN, LOCK_WIDTH, USER_WIDTH);
  localparam int O_USER   = field_offset(F_USER,   ID_WIDTH, ADDR_WIDTH, BURST_LEN, LOCK_WIDTH, USER_WIDTH);

  state_e                   state_q, state_d;
  logic                     tready_q, tready_d;
  logic                     arvalid_q, arvalid_d;
  logic                     awvalid_q, awvalid_d;
  logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d;

  logic                     beat_accept, collect_accept, handshake;
  logic                     done, done_type, short_det, long_det;
  logic [IMG_BITS-1:0]      image;

  stream_beat_assembler #(
    .DATA_WIDTH (DATA_WIDTH),
    .BEATS      (BEATS)
  ) u_assembler (
    .clk         (clk),
    .reset       (reset),
    .beat_data   (stream_tdata),
    .beat_accept (collect_accept),
    .beat_last   (stream_tlast),
    .clear       (handshake),
    .done        (done),
    .done_type   (done_type),
    .short_det   (short_det),
    .long_det    (long_det),
    .err_short   (err_short),
    .err_long    (err_long),
    .image       (image)
  );

  // Next state; tready and valids are registered from the next state so
  // valid never follows ready combinationally
  always_comb begin
    beat_accept    = stream_tvalid & tready_q;
    collect_accept = beat_accept & (state_q == ST_COLLECT);
    handshake      = (arvalid_q & AXIM_arready) | (awvalid_q & AXIM_awready);
    state_d        = state_q;
    arvalid_d      = arvalid_q;
    awvalid_d      = awvalid_q;
    case (state_q)
      ST_COLLECT: begin
        if (done) begin
          state_d   = ST_ISSUE;
          arvalid_d = (done_type == TYPE_AR);
          awvalid_d = (done_type == TYPE_AW);
        end else if (long_det) begin
          state_d = ST_DISCARD;
        end
      end
      ST_ISSUE: begin
        if (handshake) begin
          state_d   = ST_COLLECT;
          arvalid_d = 1'b0;
          awvalid_d = 1'b0;
        end
      end
      ST_DISCARD: begin
        if (beat_accept && stream_tlast) state_d = ST_COLLECT;
      end
      default: state_d = ST_COLLECT;
    endcase
    tready_d = (state_d != ST_ISSUE);

    err_count_d = err_count_q;
    if ((short_det || long_det) && (err_count_q != {ERR_CNT_WIDTH{1'b1}}))
      err_count_d = err_count_q + ERR_CNT_WIDTH'(1);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_COLLECT;
      tready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      awvalid_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      tready_q    <= tready_d;
      arvalid_q   <= arvalid_d;
      awvalid_q   <= awvalid_d;
      err_count_q <= err_count_d;
    end
  end

  assign stream_tready = tready_q;
  assign AXIM_arvalid  = arvalid_q;
  assign AXIM_awvalid  = awvalid_q;
  assign err_count     = err_count_q;

  // Both channels present the same registered fields; only the valid differs
  assign AXIM_arid     = image[O_ID     +: ID_WIDTH];
  assign AXIM_araddr   = image[O_ADDR   +: ADDR_WIDTH];
  assign AXIM_arlen    = image[O_LEN    +: BURST_LEN];
  assign AXIM_arsize   = image[O_SIZE   +: SIZE_W];
  assign AXIM_arburst  = image[O_BURST  +: BURST_W];
  assign AXIM_arlock   = image[O_LOCK   +: LOCK_WIDTH];
  assign AXIM_arcache  = image[O_CACHE  +: CACHE_W];
  assign AXIM_arprot   = image[O_PROT   +: PROT_W];
  assign AXIM_arregion = image[O_REGION +: REGION_W];
  assign AXIM_arqos    = image[O_QOS    +: QOS_W];
  assign AXIM_aruser   = image[O_USER   +: USER_WIDTH];
  assign AXIM_awid     = AXIM_arid;
  assign AXIM_awaddr   = AXIM_araddr;
  assign AXIM_awlen    = AXIM_arlen;
  assign AXIM_awsize   = AXIM_arsize;
  assign AXIM_awburst  = AXIM_arburst;
  assign AXIM_awlock   = AXIM_arlock;
  assign AXIM_awcache  = AXIM_arcache;
  assign AXIM_awprot   = AXIM_arprot;
  assign AXIM_awregion = AXIM_arregion;
  assign AXIM_awqos    = AXIM_arqos;
  assign AXIM_awuser   = AXIM_aruser;

  // Sideband stream signals carry nothing for this link
  logic unused_inputs;
  assign unused_inputs = ^{stream_tid, stream_tdest, stream_tstrb, stream_tkeep,
                           stream_tuser, image[0]};

  if (IMG_BITS > PKT_BITS) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^image[IMG_BITS-1:PKT_BITS];
  end

endmodule

`default_nettype wire

// File: tb/tb_stream_to_axi_ax.sv
// ============================================================================
// Module      : tb_stream_to_axi_ax
// Description : Self-checking bench for stream_to_axi_ax with a transaction
//               scoreboard and directed packet scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_to_axi_ax;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [127:0] stream_tdata;
  logic         stream_tvalid, stream_tlast, stream_tready;
  logic [31:0]  stream_tid, stream_tdest;
  logic [15:0]  stream_tstrb, stream_tkeep;
  logic [63:0]  stream_tuser;
  logic [31:0]  AXIM_arid, AXIM_awid;
  logic [63:0]  AXIM_araddr, AXIM_awaddr, AXIM_aruser, AXIM_awuser;
  logic [7:0]   AXIM_arlen, AXIM_awlen;
  logic [2:0]   AXIM_arsize, AXIM_awsize, AXIM_arprot, AXIM_awprot;
  logic [1:0]   AXIM_arburst, AXIM_awburst, AXIM_arlock, AXIM_awlock;
  logic [3:0]   AXIM_arcache, AXIM_awcache, AXIM_arregion, AXIM_awregion;
  logic [3:0]   AXIM_arqos, AXIM_awqos;
  logic         AXIM_arvalid, AXIM_arready, AXIM_awvalid, AXIM_awready;
  logic         err_short, err_long;
  logic [15:0]  err_count;

  stream_to_axi_ax dut (
    .clk(clk), .reset(reset),
    .stream_tdata(stream_tdata), .stream_tvalid(stream_tvalid), .stream_tlast(stream_tlast),
    .stream_tready(stream_tready), .stream_tid(stream_tid), .stream_tdest(stream_tdest),
    .stream_tstrb(stream_tstrb), .stream_tkeep(stream_tkeep), .stream_tuser(stream_tuser),
    .AXIM_arid(AXIM_arid), .AXIM_araddr(AXIM_araddr), .AXIM_arlen(AXIM_arlen),
    .AXIM_arsize(AXIM_arsize), .AXIM_arburst(AXIM_arburst), .AXIM_arlock(AXIM_arlock),
    .AXIM_arcache(AXIM_arcache), .AXIM_arprot(AXIM_arprot), .AXIM_arregion(AXIM_arregion),
    .AXIM_arqos(AXIM_arqos), .AXIM_aruser(AXIM_aruser), .AXIM_arvalid(AXIM_arvalid),
    .AXIM_arready(AXIM_arready),
    .AXIM_awid(AXIM_awid), .AXIM_awaddr(AXIM_awaddr), .AXIM_awlen(AXIM_awlen),
    .AXIM_awsize(AXIM_awsize), .AXIM_awburst(AXIM_awburst), .AXIM_awlock(AXIM_awlock),
    .AXIM_awcache(AXIM_awcache), .AXIM_awprot(AXIM_awprot), .AXIM_awregion(AXIM_awregion),
    .AXIM_awqos(AXIM_awqos), .AXIM_awuser(AXIM_awuser), .AXIM_awvalid(AXIM_awvalid),
    .AXIM_awready(AXIM_awready),
    .err_short(err_short), .err_long(err_long), .err_count(err_count)
  );

  typedef struct packed {
    logic        typ;
    logic [31:0] id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [1:0]  lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  region;
    logic [3:0]  qos;
    logic [63:0] user;
  } txn_t;

  int   checks = 0;
  int   passes = 0;
  txn_t exp_q[$];
  int   exp_short = 0;
  int   exp_long  = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic txn_t mk(input logic typ, input logic [31:0] id, input logic [63:0] addr,
                              input logic [7:0] len, input logic [2:0] size,
                              input logic [1:0] burst, input logic [63:0] user);
    txn_t t;
    t.typ = typ; t.id = id; t.addr = addr; t.len = len; t.size = size; t.burst = burst;
    t.lock = id[1:0]; t.cache = 4'h3; t.prot = 3'h5; t.region = 4'hC; t.qos = 4'h6;
    t.user = user;
    return t;
  endfunction

  // Packet image: type, id, addr, len, size, burst, lock, cache, prot, region, qos, user, LSB first
  function automatic logic [383:0] build_image(input txn_t t);
    return {193'b0, t.user, t.qos, t.region, t.prot, t.cache, t.lock, t.burst, t.size,
            t.len, t.addr, t.id, t.typ};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  int   cyc = 0;
  int   last_tlast_acc = -10;
  int   last_any_acc = -10;
  int   vcycles = 0;
  int   valid_len_last = 0;
  int   hs_ar = 0;
  int   hs_aw = 0;
  int   n_short = 0;
  int   n_long = 0;
  int   hs_cyc[$];
  logic prev_ar_pend = 1'b0, prev_aw_pend = 1'b0, prev_valid = 1'b0;
  logic prev_short = 1'b0, prev_long = 1'b0;
  txn_t prev_ar, prev_aw, a_ar, a_aw, last_hs, e;

  always @(negedge clk) begin
    cyc++;
    a_ar = '{typ:1'b0, id:AXIM_arid, addr:AXIM_araddr, len:AXIM_arlen, size:AXIM_arsize,
             burst:AXIM_arburst, lock:AXIM_arlock, cache:AXIM_arcache, prot:AXIM_arprot,
             region:AXIM_arregion, qos:AXIM_arqos, user:AXIM_aruser};
    a_aw = '{typ:1'b1, id:AXIM_awid, addr:AXIM_awaddr, len:AXIM_awlen, size:AXIM_awsize,
             burst:AXIM_awburst, lock:AXIM_awlock, cache:AXIM_awcache, prot:AXIM_awprot,
             region:AXIM_awregion, qos:AXIM_awqos, user:AXIM_awuser};
    if (reset) begin
      prev_ar_pend = 1'b0; prev_aw_pend = 1'b0; prev_valid = 1'b0;
      prev_short = 1'b0; prev_long = 1'b0; vcycles = 0;
    end else begin
      if (AXIM_arvalid || AXIM_awvalid) begin
        check("valid_onehot", AXIM_arvalid & AXIM_awvalid, 0);
        check("tready_low_while_valid", stream_tready, 0);
        vcycles++;
        if (!prev_valid) check("valid_latency", cyc, last_tlast_acc + 1);
      end
      if (prev_ar_pend) check("ar_hold", {AXIM_arvalid, a_ar}, {1'b1, prev_ar});
      if (prev_aw_pend) check("aw_hold", {AXIM_awvalid, a_aw}, {1'b1, prev_aw});
      if ((AXIM_arvalid && AXIM_arready) || (AXIM_awvalid && AXIM_awready)) begin
        if (AXIM_arvalid) begin hs_ar++; last_hs = a_ar; end
        else              begin hs_aw++; last_hs = a_aw; end
        hs_cyc.push_back(cyc);
        valid_len_last = vcycles;
        vcycles = 0;
        if (exp_q.size() == 0) begin
          check("unexpected_handshake", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("txn_fields", last_hs, e);
        end
      end
      if (err_short) begin
        n_short++;
        check("short_timing", cyc, last_any_acc + 1);
        check("short_width", prev_short, 0);
      end
      if (err_long) begin
        n_long++;
        check("long_timing", cyc, last_any_acc + 1);
        check("long_width", prev_long, 0);
      end
      if (stream_tvalid && stream_tready) begin
        last_any_acc = cyc;
        if (stream_tlast) last_tlast_acc = cyc;
      end
      prev_ar_pend = AXIM_arvalid && !AXIM_arready;
      prev_aw_pend = AXIM_awvalid && !AXIM_awready;
      prev_ar = a_ar;
      prev_aw = a_aw;
      prev_valid = AXIM_arvalid || AXIM_awvalid;
      prev_short = err_short;
      prev_long = err_long;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [127:0] d, input logic l);
    int t;
    t = 0;
    stream_tvalid = 1'b1;
    stream_tdata  = d;
    stream_tlast  = l;
    while (!stream_tready && t < 100) begin step(); t++; end
    check("beat_accept_timeout", stream_tready, 1);
    step();
  endtask

  task automatic idle();
    stream_tvalid = 1'b0;
    stream_tlast  = 1'b0;
  endtask

  task automatic send_raw(input logic [383:0] img, input int n);
    for (int k = 0; k < n; k++) send_beat(img[k*128 +: 128], k == n - 1);
  endtask

  // Two beats with tlast on the second form a well-formed packet
  task automatic send_packet(input txn_t t);
    exp_q.push_back(t);
    send_raw(build_image(t), 2);
  endtask

  task automatic wait_hs(input int n);
    int t;
    t = 0;
    while ((hs_ar + hs_aw) < n && t < 200) begin step(); t++; end
    check("handshake_count", hs_ar + hs_aw, n);
  endtask

  int   base;
  int   t;
  txn_t tx;

  initial begin
    reset = 1'b1; stream_tdata = '0; stream_tvalid = 1'b0; stream_tlast = 1'b0;
    stream_tid = 32'hDEAD; stream_tdest = 32'h7; stream_tstrb = '1; stream_tkeep = '1;
    stream_tuser = 64'h55;
    AXIM_arready = 1'b0; AXIM_awready = 1'b0;

    // Reset values
    repeat (3) step();
    @(negedge clk);
    check("reset_tready", stream_tready, 0);
    check("reset_valids", {AXIM_arvalid, AXIM_awvalid}, 0);
    check("reset_fields", {AXIM_araddr, AXIM_arid, AXIM_awuser}, 0);
    check("reset_errs", {err_short, err_long, err_count}, 0);
    step();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("tready_after_reset", stream_tready, 1);
    step();

    // AR packet with ready high
    AXIM_arready = 1'b1;
    send_packet(mk(1'b0, 32'h5, 64'h1000_0000, 8'd7, 3'd4, 2'd1, 64'h0));
    idle();
    wait_hs(1);
    check("ar_addr", last_hs.addr, 64'h1000_0000);
    check("ar_id_len_size_burst", {last_hs.id, last_hs.len, last_hs.size, last_hs.burst},
          {32'h5, 8'd7, 3'd4, 2'd1});
    check("ar_valid_cycles", valid_len_last, 1);
    check("no_aw_yet", hs_aw, 0);

    // AW packet with ready held low for five cycles
    AXIM_awready = 1'b0;
    send_packet(mk(1'b1, 32'hA, 64'hFFFF_0000_0000_0040, 8'd0, 3'd2, 2'd1, 64'h1234));
    idle();
    t = 0;
    while (!AXIM_awvalid && t < 20) begin step(); t++; end
    check("awvalid_rise", AXIM_awvalid, 1);
    repeat (5) step();
    AXIM_awready = 1'b1;
    wait_hs(2);
    check("aw_valid_cycles", valid_len_last, 6);
    check("aw_handshakes", hs_aw, 1);
    check("aw_addr_user", {last_hs.addr, last_hs.user}, {64'hFFFF_0000_0000_0040, 64'h1234});

    // Short packet, then a good AR
    send_raw(build_image(mk(1'b0, 32'h99, 64'h0, 8'd0, 3'd0, 2'd0, 64'h0)), 1);
    exp_short++;
    idle();
    step(); step();
    check("err_count_after_short", err_count, 1);
    send_packet(mk(1'b0, 32'h22, 64'h2000_1000, 8'd3, 3'd3, 2'd2, 64'hBEEF));
    idle();
    wait_hs(3);

    // Long packet (three beats), then a good AW
    send_raw(build_image(mk(1'b1, 32'h33, 64'h3000, 8'd1, 3'd1, 2'd1, 64'h1)), 3);
    exp_long++;
    idle();
    step(); step();
    check("err_count_after_long", err_count, 2);
    check("long_no_valid", {AXIM_arvalid, AXIM_awvalid}, 0);
    send_packet(mk(1'b1, 32'h44, 64'h4000_0000_0000, 8'd15, 3'd2, 2'd1, 64'hCAFE));
    idle();
    wait_hs(4);

    // Reset in the cycle after the first beat of a packet
    tx = mk(1'b1, 32'h66, 64'h6666, 8'd2, 3'd1, 2'd0, 64'h6);
    send_beat(build_image(tx) >> 0, 1'b0);
    idle();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    step();
    check("err_count_after_reset", err_count, 0);
    send_packet(mk(1'b1, 32'h77, 64'h7777_0000, 8'd4, 3'd5, 2'd1, 64'h77));
    idle();
    wait_hs(5);
    check("post_reset_aw_id", last_hs.id, 32'h77);

    // Ten back-to-back AR packets
    AXIM_arready = 1'b1;
    base = hs_cyc.size();
    for (int i = 0; i < 10; i++)
      send_packet(mk(1'b0, 32'h100 + i, 64'h8000_0000 + 64'(i * 64), 8'(i), 3'd3, 2'd1, 64'(i)));
    idle();
    wait_hs(15);
    if (hs_cyc.size() >= base + 10)
      check("b2b_spacing", hs_cyc[base + 9] - hs_cyc[base], 27);
    else
      check("b2b_count", hs_cyc.size() - base, 10);

    repeat (4) step();
    check("scoreboard_drained", exp_q.size(), 0);
    check("short_pulses", n_short, exp_short);
    check("long_pulses", n_long, exp_long);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
